load_store_unit: RTL and testbench

Execute-stage load/store unit sitting directly upstream of the main dual-port memory's data port. It accepts RV32 load/store requests carrying byte addresses, converts them to the memory's word-indexed req/ack protocol, and performs naturally aligned byte and halfword accesses. Sub-word stores use read-modify-write, because the memory has no byte enables. Load results are aligned and sign- or zero-extended before going to writeback.

---
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Execute-stage load/store unit: converts RV32 byte-addressed loads/stores into
// word-indexed req/ack memory accesses, using read-modify-write for SB/SH.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; inputs sampled here only
// RD    | memory read (loads, read phase of SB/SH)
// WR    | memory write (SW, write phase of SB/SH)
// RESP  | one-cycle completion, done_o (and err_o if rejected)
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_req_i,
    input  logic            st_req_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [XLEN-1:0] ld_data_o,
    output logic            mem_req_o,
    output logic            mem_wen_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t state_q, state_d;

    logic [XLEN-1:0] addr_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] st_data_q;
    logic            is_store_q;
    logic            err_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] ld_data_q;

    logic            any_req;
    logic            accept;
    logic            f3_legal;
    logic            misaligned;
    logic            reject;
    logic            is_sw;

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] merge_word;

    // Request qualification, evaluated on the raw inputs in IDLE
    always_comb begin
        any_req  = ld_req_i | st_req_i;
        accept   = (state_q == IDLE) && any_req;
        f3_legal = 1'b0;
        if (st_req_i) begin
            f3_legal = (funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W);
        end else begin
            f3_legal = (funct3_i == F3_B)  || (funct3_i == F3_H) || (funct3_i == F3_W) ||
                       (funct3_i == F3_BU) || (funct3_i == F3_HU);
        end
        misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        reject     = (ld_req_i && st_req_i) || !f3_legal || misaligned;
        is_sw      = st_req_i && (funct3_i == F3_W);
    end

    // Load lane extraction and sub-word merge both work on the live read word
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

        ld_ext = mem_rdata_i;
        case (funct3_q)
            F3_B:    ld_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ld_ext = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ld_ext = {24'h000000, byte_sel};
            F3_HU:   ld_ext = {16'h0000, half_sel};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        merge_word = mem_rdata_i;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merge_word[7:0]   = st_data_q[7:0];
                2'd1:    merge_word[15:8]  = st_data_q[7:0];
                2'd2:    merge_word[23:16] = st_data_q[7:0];
                default: merge_word[31:24] = st_data_q[7:0];
            endcase
        end else begin
            if (addr_q[1]) begin
                merge_word[31:16] = st_data_q[15:0];
            end else begin
                merge_word[15:0]  = st_data_q[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (reject) begin
                        state_d = RESP;
                    end else if (is_sw) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (mem_ack_i) begin
                    state_d = is_store_q ? WR : RESP;
                end
            end
            WR: begin
                if (mem_ack_i) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == RESP);
        err_o       = (state_q == RESP) && err_q;
        mem_req_o   = (state_q == RD) || (state_q == WR);
        mem_wen_o   = (state_q == WR);
        mem_wdata_o = (state_q == WR) ? wdata_q : '0;
        mem_addr_o  = {2'b00, addr_q[XLEN-1:2]};
        ld_data_o   = ld_data_q;
    end

    // Request capture, load result and write word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            funct3_q   <= '0;
            st_data_q  <= '0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            ld_data_q  <= '0;
        end else begin
            if (accept) begin
                addr_q     <= addr_i;
                funct3_q   <= funct3_i;
                st_data_q  <= st_data_i;
                is_store_q <= st_req_i;
                err_q      <= reject;
                wdata_q    <= st_data_i;
            end
            if ((state_q == RD) && mem_ack_i) begin
                if (is_store_q) begin
                    wdata_q <= merge_word;
                end else begin
                    ld_data_q <= ld_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: req/ack memory model plus an arithmetic
// reference model of RV32 sub-word load/store semantics.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        ld_req, st_req;
    logic [2:0]  funct3;
    logic [31:0] addr, st_data;
    logic        busy, done, err;
    logic [31:0] ld_data;
    logic        mem_req, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tb_mem  [64];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_ld;
    int          max_lat;
    int          wait_cnt;
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;
    logic [2:0]  ld_f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req_i(ld_req), .st_req_i(st_req), .funct3_i(funct3),
        .addr_i(addr), .st_data_i(st_data),
        .busy_o(busy), .done_o(done), .err_o(err), .ld_data_o(ld_data),
        .mem_req_o(mem_req), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory with a one-cycle ack that clears on the following edge
    always @(posedge clk) begin
        if (bd_we) begin
            tb_mem[bd_idx] <= bd_data;
        end else if (mem_ack) begin
            mem_ack <= 1'b0;
        end else if (mem_req) begin
            if (wait_cnt == 0) begin
                if (mem_wen) tb_mem[mem_addr[5:0]] <= mem_wdata;
                mem_rdata <= tb_mem[mem_addr[5:0]];
                mem_ack   <= 1'b1;
                wait_cnt  <= $urandom_range(0, max_lat);
            end else begin
                wait_cnt <= wait_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke_mem(input int idx, input logic [31:0] val);
        bd_idx  = idx[5:0];
        bd_data = val;
        bd_we   = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
        ref_mem[idx] = val;
    endtask

    // RV32 semantics computed from sizes, shifts and masks
    function automatic void model(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] old, output bit e,
                                  output logic [31:0] ldv, output logic [31:0] neww);
        int size, sh;
        logic [31:0] mask, v;
        e = 0; ldv = 0; neww = old;
        if (ld && st) e = 1;
        else if (ld) e = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else e = !(f3 == 0 || f3 == 1 || f3 == 2);
        if (e) return;
        size = 1 << f3[1:0];
        if ((a % size) != 0) begin e = 1; return; end
        sh   = (a % 4) * 8;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
        if (ld) begin
            v = (old >> sh) & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            ldv = v;
        end else begin
            neww = (old & ~(mask << sh)) | ((d << sh) & (mask << sh));
        end
    endfunction

    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input int exp_cyc, input bit poke);
        bit e_err, seen_req, timeout;
        logic [31:0] e_ld, e_word;
        int idx, cyc;
        idx = int'(a[7:2]);
        model(ld, st, f3, a, d, ref_mem[idx], e_err, e_ld, e_word);
        @(negedge clk);
        ld_req = ld; st_req = st; funct3 = f3; addr = a; st_data = d;
        cyc = 0; seen_req = 0; timeout = 1;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                ld_req  = poke; st_req = 1'b0;
                funct3  = poke ? 3'b010 : 3'($urandom);
                addr    = poke ? 32'h0 : $urandom;
                st_data = $urandom;
            end
            if (mem_req && !seen_req) begin
                seen_req = 1;
                chk("mem_addr", mem_addr, {2'b00, a[31:2]});
            end
            if (done) begin timeout = 0; break; end
        end
        ld_req = 0; st_req = 0;
        chk("timeout", 32'(timeout), 32'd0);
        if (exp_cyc > 0) chk("latency", cyc, exp_cyc);
        chk("err", 32'(err), 32'(e_err));
        if (e_err) chk("no_mem_req", 32'(seen_req), 32'd0);
        @(negedge clk);
        chk("gap_busy", 32'(busy), 32'd0);
        chk("extra_done", 32'(done), 32'd0);
        if (ld && !st && !e_err) exp_ld = e_ld;
        chk("ld_data", ld_data, exp_ld);
        ref_mem[idx] = e_word;
        chk("mem_word", tb_mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] a, amask;
        logic [2:0]  f3;
        bit          ld, st;
        int          r;
        rst_n = 0; ld_req = 0; st_req = 0; funct3 = 0; addr = 0; st_data = 0;
        bd_we = 0; bd_idx = 0; bd_data = 0; mem_ack = 0; mem_rdata = 0;
        wait_cnt = 0; max_lat = 0; exp_ld = 0;
        for (int i = 0; i < 64; i++) poke_mem(i, $urandom);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_ld", ld_data, 0);
        rst_n = 1;

        poke_mem(4, 32'hDEADBEEF);
        do_op(1, 0, 3'b010, 32'h10, 0, 3, 0);
        chk("lw_value", ld_data, 32'hDEADBEEF);
        poke_mem(4, 32'h80FF7F01);
        do_op(1, 0, 3'b000, 32'h13, 0, 3, 0);
        chk("lb_value", ld_data, 32'hFFFFFF80);
        do_op(1, 0, 3'b100, 32'h13, 0, 3, 0);
        chk("lbu_value", ld_data, 32'h00000080);
        do_op(1, 0, 3'b001, 32'h12, 0, 3, 0);
        chk("lh_value", ld_data, 32'hFFFF80FF);
        do_op(1, 0, 3'b101, 32'h12, 0, 3, 0);
        do_op(1, 0, 3'b000, 32'h10, 0, 3, 0);
        poke_mem(8, 32'h11223344);
        do_op(0, 1, 3'b000, 32'h21, 32'hCDEF12AB, 5, 0);
        chk("sb_word", tb_mem[8], 32'h1122AB44);
        do_op(0, 1, 3'b001, 32'h22, 32'h9999BEEF, 5, 0);
        do_op(0, 1, 3'b010, 32'h24, 32'h0BADF00D, 3, 0);
        do_op(0, 1, 3'b001, 32'h01, 32'h5555, 1, 0);
        do_op(0, 1, 3'b010, 32'h02, 32'h7777, 1, 0);
        do_op(1, 1, 3'b010, 32'h10, 0, 1, 0);
        do_op(1, 0, 3'b011, 32'h10, 0, 1, 0);
        do_op(0, 1, 3'b100, 32'h10, 0, 1, 0);
        do_op(1, 0, 3'b010, 32'h20, 0, 3, 1);

        // Reset in the first write cycle of an SB abandons the RMW
        poke_mem(8, 32'h55667788);
        @(negedge clk);
        st_req = 1; funct3 = 3'b000; addr = 32'h21; st_data = 32'hEE;
        @(negedge clk); st_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rmw_in_wr", 32'(mem_wen), 1);
        rst_n = 0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_req", 32'(mem_req), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_wen", 32'(mem_wen), 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_ld", ld_data, 0);
        exp_ld = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        chk("arst_word", tb_mem[8], 32'h55667788);
        do_op(1, 0, 3'b010, 32'h20, 0, 3, 0);
        chk("arst_lw", ld_data, 32'h55667788);

        max_lat = 2;
        for (int k = 0; k < 80; k++) begin
            r  = $urandom_range(0, 9);
            ld = (r < 5);
            st = (r >= 4);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
            else if (ld) f3 = ld_f3s[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 2));
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) begin
                amask = (32'd1 << f3[1:0]) - 32'd1;
                a = a & ~amask;
            end
            do_op(ld, st, f3, a, $urandom, -1, ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
